// File: rtl/ysyx_23060136_bht_ctrl.sv
// Branch history table of 2-bit saturating counters, untagged, indexed by pc[IDX_W+1:2].
// Lookup is zero-latency combinational; updates land on the next edge; clear sweeps one entry per cycle.
module ysyx_23060136_bht_ctrl #(
    parameter int ENTRY_NUM = 16,
    parameter int IDX_W     = 4,
    parameter int BITS_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_W-1:0] IFU_pc,
    output logic              IFU_pre_take,
    input  logic [BITS_W-1:0] BHT_pc,
    input  logic              BHT_pre_true,
    input  logic              BHT_pre_false,
    input  logic              BHT_pre_take,
    input  logic              bht_clear,
    output logic              clear_busy,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    logic [1:0]       cnt [ENTRY_NUM];

    logic [IDX_W-1:0] ifu_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_vld;
    logic             upd_taken;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_nxt;

    assign ifu_idx   = IFU_pc[IDX_W+1:2];
    assign upd_idx   = BHT_pc[IDX_W+1:2];
    assign upd_vld   = BHT_pre_true ^ BHT_pre_false;
    assign upd_taken = BHT_pre_take ^ BHT_pre_false;
    assign cnt_cur   = cnt[upd_idx];

    // Only the index bits take part; the rest of each PC is deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IFU_pc[BITS_W-1:IDX_W+2], IFU_pc[1:0],
                              BHT_pc[BITS_W-1:IDX_W+2], BHT_pc[1:0]};

    always_comb begin
        cnt_nxt = cnt_cur;
        if (upd_taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
        end
    end

    // Read is taken before any same-cycle write, so there is no bypass path.
    assign IFU_pre_take = (state == IDLE) && cnt[ifu_idx][1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            clr_idx    <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bht_clear) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (bht_clear) begin
                        clr_idx <= '0;
                    end else if (clr_idx == IDX_W'(ENTRY_NUM - 1)) begin
                        state      <= IDLE;
                        clr_idx    <= '0;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Updates arriving while clearing, or alongside a clear request, are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) cnt[i] <= 2'b01;
        end else if (state == CLEAR) begin
            cnt[clr_idx] <= 2'b01;
        end else if (upd_vld && !bht_clear) begin
            cnt[upd_idx] <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else if (upd_vld) begin
            if (BHT_pre_true) perf_hit  <= perf_hit + 32'd1;
            else              perf_miss <= perf_miss + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_bht_ctrl.sv
// Directed bench for the branch history table: lookup, saturation, no-bypass, clear sweep, reset abort.
`timescale 1ns/100ps
module tb_ysyx_23060136_bht_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] IFU_pc;
    logic        IFU_pre_take;
    logic [31:0] BHT_pc;
    logic        BHT_pre_true;
    logic        BHT_pre_false;
    logic        BHT_pre_take;
    logic        bht_clear;
    logic        clear_busy;
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;

    int total = 0;
    int bad   = 0;
    int n;

    ysyx_23060136_bht_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .IFU_pc        (IFU_pc),
        .IFU_pre_take  (IFU_pre_take),
        .BHT_pc        (BHT_pc),
        .BHT_pre_true  (BHT_pre_true),
        .BHT_pre_false (BHT_pre_false),
        .BHT_pre_take  (BHT_pre_take),
        .bht_clear     (bht_clear),
        .clear_busy    (clear_busy),
        .perf_hit      (perf_hit),
        .perf_miss     (perf_miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        IFU_pc = pc;
        #1;
        chk(tag, {31'b0, IFU_pre_take}, {31'b0, exp});
    endtask

    task automatic upd(input logic [31:0] pc, input logic take, input logic t, input logic f);
        BHT_pc        = pc;
        BHT_pre_take  = take;
        BHT_pre_true  = t;
        BHT_pre_false = f;
        step();
        BHT_pre_true  = 1'b0;
        BHT_pre_false = 1'b0;
        BHT_pre_take  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        IFU_pc = 32'h8000_0000;
        BHT_pc = 32'h8000_0000;
        BHT_pre_true = 1'b0;
        BHT_pre_false = 1'b0;
        BHT_pre_take = 1'b0;
        bht_clear = 1'b0;

        #3;
        chk("rst_busy", {31'b0, clear_busy}, 32'd0);
        chk("rst_hit", perf_hit, 32'd0);
        chk("rst_miss", perf_miss, 32'd0);
        chk("rst_pred", {31'b0, IFU_pre_take}, 32'd0);
        #5 rst = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            look("init_pred", 32'h8000_0000 + 32'(4 * i), 1'b0);
            step();
        end
        chk("init_hit", perf_hit, 32'd0);
        chk("init_miss", perf_miss, 32'd0);

        // Two taken reports at idx 2: one mispredicted, one correct.
        upd(32'h8000_0008, 1'b0, 1'b0, 1'b1);
        upd(32'h8000_0008, 1'b1, 1'b1, 1'b0);
        look("taken_pred", 32'h8000_0008, 1'b1);
        look("alias_pred", 32'h8000_0048, 1'b1);
        look("neighbour_pred", 32'h8000_000C, 1'b0);
        chk("taken_hit", perf_hit, 32'd1);
        chk("taken_miss", perf_miss, 32'd1);

        // Drive idx 1 to 11, then four not-taken: 10,01,00,00.
        upd(32'h8000_0004, 1'b1, 1'b1, 1'b0);
        upd(32'h8000_0004, 1'b1, 1'b1, 1'b0);
        upd(32'h8000_0004, 1'b1, 1'b0, 1'b1);
        look("sat_1", 32'h8000_0004, 1'b1);
        upd(32'h8000_0004, 1'b1, 1'b0, 1'b1);
        look("sat_2", 32'h8000_0004, 1'b0);
        upd(32'h8000_0004, 1'b1, 1'b0, 1'b1);
        look("sat_3", 32'h8000_0004, 1'b0);
        upd(32'h8000_0004, 1'b1, 1'b0, 1'b1);
        look("sat_4", 32'h8000_0004, 1'b0);
        upd(32'h8000_0004, 1'b1, 1'b1, 1'b0);
        look("sat_floor", 32'h8000_0004, 1'b0);
        chk("sat_hit", perf_hit, 32'd4);
        chk("sat_miss", perf_miss, 32'd5);

        // Same-cycle update and lookup at idx 3 (01 -> 10).
        IFU_pc = 32'h8000_000C;
        BHT_pc = 32'h8000_000C;
        BHT_pre_take = 1'b1;
        BHT_pre_true = 1'b1;
        #1;
        chk("nobypass_old", {31'b0, IFU_pre_take}, 32'd0);
        step();
        BHT_pre_true = 1'b0;
        BHT_pre_take = 1'b0;
        #1;
        chk("nobypass_new", {31'b0, IFU_pre_take}, 32'd1);

        // Both flags high: rejected.
        upd(32'h8000_000C, 1'b1, 1'b1, 1'b1);
        look("both_pred", 32'h8000_000C, 1'b1);
        chk("both_hit", perf_hit, 32'd5);
        chk("both_miss", perf_miss, 32'd5);

        // Clear, with accepted updates on the request cycle and mid-sweep.
        IFU_pc = 32'h8000_0008;
        bht_clear = 1'b1;
        BHT_pc = 32'h8000_0008;
        BHT_pre_take = 1'b1;
        BHT_pre_false = 1'b1;
        #1;
        chk("preclear_busy", {31'b0, clear_busy}, 32'd0);
        chk("preclear_pred", {31'b0, IFU_pre_take}, 32'd1);
        step();
        bht_clear = 1'b0;
        BHT_pre_take = 1'b0;
        BHT_pre_false = 1'b0;
        n = 0;
        while (clear_busy === 1'b1 && n < 40) begin
            n++;
            if (n == 1) look("clear_force0", 32'h8000_0008, 1'b0);
            if (n == 2) begin
                BHT_pc = 32'h8000_0000;
                BHT_pre_take = 1'b1;
                BHT_pre_true = 1'b1;
            end
            step();
            BHT_pre_true = 1'b0;
            BHT_pre_take = 1'b0;
        end
        chk("clear_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            look("post_clear_pred", 32'h8000_0000 + 32'(4 * i), 1'b0);
        end
        chk("clear_hit", perf_hit, 32'd6);
        chk("clear_miss", perf_miss, 32'd6);

        // Re-pulse during the 8th busy cycle restarts the sweep.
        bht_clear = 1'b1;
        step();
        bht_clear = 1'b0;
        n = 0;
        while (clear_busy === 1'b1 && n < 60) begin
            n++;
            if (n == 8) bht_clear = 1'b1;
            step();
            bht_clear = 1'b0;
        end
        chk("repulse_len", 32'(n), 32'd24);

        // Reset in the middle of a clear.
        upd(32'h8000_0014, 1'b1, 1'b1, 1'b0);
        upd(32'h8000_0014, 1'b1, 1'b1, 1'b0);
        look("pre_abort_pred", 32'h8000_0014, 1'b1);
        bht_clear = 1'b1;
        step();
        bht_clear = 1'b0;
        step();
        step();
        chk("abort_busy_before", {31'b0, clear_busy}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", {31'b0, clear_busy}, 32'd0);
        chk("abort_hit", perf_hit, 32'd0);
        chk("abort_miss", perf_miss, 32'd0);
        look("abort_pred", 32'h8000_0014, 1'b0);
        #1 rst = 1'b1;
        step();
        chk("resume_busy", {31'b0, clear_busy}, 32'd0);
        look("resume_pred", 32'h8000_0014, 1'b0);
        upd(32'h8000_0014, 1'b1, 1'b1, 1'b0);
        look("resume_upd_pred", 32'h8000_0014, 1'b1);
        chk("resume_hit", perf_hit, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060136_bht_ctrl.md
YSYX_23060136_BHT_CTRL -- requirements
Module: ysyx_23060136_BHT_CTRL

Interface
REQ-001 SHALL take parameter ENTRY_NUM, default 16, number of 2-bit counter entries (power of two, 4..64).
REQ-002 SHALL take parameter IDX_W, default 4, equal to log2(ENTRY_NUM).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IFU_pc  input  BITS_W  fetch PC to predict.
REQ-006 SHALL have port IFU_pre_take  output  1  prediction for IFU_pc (1 = taken).
REQ-007 SHALL have port BHT_pc  input  BITS_W  PC of the resolved branch from the EXU branch unit.
REQ-008 SHALL have port BHT_pre_true  input  1  resolved branch was predicted correctly.
REQ-009 SHALL have port BHT_pre_false  input  1  resolved branch was mispredicted.
REQ-010 SHALL have port BHT_pre_take  input  1  prediction originally issued for BHT_pc.
REQ-011 SHALL have port bht_clear  input  1  one-cycle request to reinitialise the table (fence.i / context switch).
REQ-012 SHALL have port clear_busy  output  1  high while the table is being reinitialised.
REQ-013 SHALL have port perf_hit  output  32  count of accepted correct-prediction reports.
REQ-014 SHALL have port perf_miss  output  32  count of accepted misprediction reports.

Function
REQ-015 SHALL hold ENTRY_NUM 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 SHALL index both lookup and update with pc[IDX_W+1:2]; pc[1:0] and upper bits ignored, no tag.
REQ-017 SHALL drive IFU_pre_take combinationally = counter[idx(IFU_pc)][1], zero-cycle latency, in IDLE.
REQ-018 SHALL force IFU_pre_take = 0 while in state CLEAR.
REQ-019 SHALL define an update as accepted when exactly one of BHT_pre_true / BHT_pre_false is high; both high or both low -> no table write, no perf count.
REQ-020 SHALL compute actual outcome = BHT_pre_take XOR BHT_pre_false for an accepted update.
REQ-021 SHALL, on an accepted update in IDLE, write counter+1 if outcome taken (saturate at 11), counter-1 if not taken (saturate at 00), at the next rising edge.
REQ-022 SHALL not bypass: a lookup in the same cycle as an update to the same index returns the pre-update value; new value visible from the next cycle.
REQ-023 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on bht_clear=1; CLEAR -> IDLE after the cycle writing index ENTRY_NUM-1.
REQ-024 SHALL, in CLEAR, write 01 to one entry per cycle using a clear index starting at 0, so CLEAR lasts exactly ENTRY_NUM cycles.
REQ-025 SHALL restart the clear index at 0 if bht_clear is asserted again during CLEAR.
REQ-026 SHALL drop (not write) accepted updates while in CLEAR, and on the cycle bht_clear is sampled in IDLE.
REQ-027 SHALL drive clear_busy = 1 exactly while state is CLEAR (registered, from the cycle after bht_clear).
REQ-028 SHALL increment perf_hit on every accepted update with BHT_pre_true, and perf_miss with BHT_pre_false, in any state; both wrap 0xFFFF_FFFF -> 0.

Reset
REQ-029 SHALL, on rst low, immediately set every counter to 01, state IDLE, clear index 0, perf_hit = perf_miss = 0, clear_busy = 0 (IFU_pre_take hence 0).
REQ-030 SHALL resume normal operation on the first rising edge after rst deasserts; reset mid-CLEAR aborts the clear and returns to IDLE with all counters 01.

Verification
REQ-031 SHALL cover: reset, then lookup PCs 0x8000_0000..0x8000_003C -> IFU_pre_take = 0 for all, perf_hit = perf_miss = 0.
REQ-032 SHALL cover: two accepted taken updates (pre_take=0,pre_false=1 then pre_take=1,pre_true=1) at 0x8000_0008 -> counter 01->10->11, IFU_pre_take=1 at 0x8000_0008 and at alias 0x8000_0048, perf_hit=1, perf_miss=1.
REQ-033 SHALL cover: four not-taken updates at 0x8000_0004 from 11 -> counter saturates at 00, never wraps to 11.
REQ-034 SHALL cover: update and lookup of the same index in one cycle -> old prediction that cycle, new one next cycle.
REQ-035 SHALL cover: bht_clear with ENTRY_NUM=16 -> clear_busy high exactly 16 cycles, updates during it dropped but counted in perf, all entries 01 afterwards; re-pulse at cycle 8 extends to 24 total.
REQ-036 SHALL cover: BHT_pre_true and BHT_pre_false both high -> no table change, no perf increment; rst asserted mid-CLEAR -> IDLE, clear_busy=0 without a clock edge.
